mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single AXI read channel to main memory between the line-fill requesters:
  - requester 0: D-cache
  - requester 1: I-cache
  - requester 2: instruction stream buffer / prefetcher
- Sits between the requesters' read ports and the memory-side axi_read_address/axi_read_data master. Sequences one burst at a time: address phase, then data beats routed back to the owner until RLAST.

Parameters:
- NUM_REQ, 3, number of requesters; index 0 is highest fixed priority.
- ADDR_WIDTH, 32, read address width.
- DATA_WIDTH, 32, beat width.
- LEN_WIDTH, 4, burst length field width.
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*ADDR_WIDTH  line-aligned burst address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_len  in  NUM_REQ*LEN_WIDTH  beats in burst, 0 illegal
- req_grant  out  NUM_REQ  one-hot, 1-cycle pulse when request accepted by memory
- rsp_valid  out  NUM_REQ  one-hot, beat valid for owner
- rsp_last  out  1  final beat of burst
- rsp_data  out  DATA_WIDTH  beat data, shared by all requesters
- ARADDR  out  ADDR_WIDTH  to memory
- ARLEN  out  LEN_WIDTH  to memory
- ARID  out  ID_WIDTH  equals owner index
- ARVALID  out  1
- ARREADY  in  1
- RDATA  in  DATA_WIDTH
- RID  in  ID_WIDTH
- RLAST  in  1
- RVALID  in  1
- RREADY  out  1
- id_err  out  1  sticky, set on beat with RID != owner

Behaviour:
- Reset:
  - state IDLE, owner 0, rr pointer 0.
  - ARVALID=0, ARADDR/ARLEN/ARID=0, RREADY=0.
  - req_grant=0, rsp_valid=0, rsp_last=0, rsp_data=0, id_err=0.
  - Reset asserted mid-burst abandons the burst; beats arriving after reset release are ignored: RREADY is 0 in IDLE.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any req_valid, select winner: lowest index in fixed-priority mode.
  - Register ARADDR/ARLEN from the winner, ARID=winner index, owner=winner; next ADDR.
  - Arbitration decision uses the current-cycle req_valid; 1-cycle IDLE→ADDR latency.
- ADDR:
  - ARVALID=1; address fields held stable until ARREADY.
  - On ARVALID&&ARREADY: req_grant[owner] pulses that cycle; next DATA.
  - Requester must hold req_valid/addr/len until its grant; drop before grant is illegal (assertion).
  - Grant does not imply data.
- DATA:
  - RREADY=1.
  - Each RVALID: rsp_valid[owner]=1, rsp_data=RDATA, rsp_last=RLAST, combinational pass-through (0 latency).
  - RID != ARID: beat still forwarded, id_err set sticky until rst.
  - RVALID&&RLAST: next IDLE; new arbitration the following cycle. Minimum 1 idle cycle between bursts.
  - Beat count not checked against ARLEN; RLAST is authoritative.
- At most one outstanding burst; no interleaving.
- Simultaneous requests: exactly one winner; losers keep req_valid and win later.
- Winner's req_valid deasserting during DATA has no effect on the burst.
- No starvation guarantee in fixed-priority mode.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration; search starts at rr_ptr.
  - On each grant, rr_ptr = winner+1 mod NUM_REQ; wrap from NUM_REQ-1 to 0.
  - Guarantees each waiting requester is served within NUM_REQ bursts.
- Undefined: fixed priority, index 0 highest; rr_ptr absent.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ADDR, DATA); requester index constants REQ_DCACHE=0, REQ_ICACHE=1, REQ_SBUF=2.
- Sub-module mem_arb_picker: combinational one-hot winner select from req_valid and rr_ptr; fixed-priority or round-robin per MEM_ARB_RR_EN.

Test Plan:
- Single I-cache request, addr 0x0000_1040, len 4; ARREADY after 2 cycles:
  - ARADDR=0x1040, ARID=1.
  - req_grant[1] pulses once.
  - 4 beats on rsp_valid[1], rsp_last on the 4th; back to IDLE.
- req_valid=3'b111 same cycle, fixed priority → service order 0,1,2. With MEM_ARB_RR_EN and rr_ptr=1 → order 1,2,0.
- RVALID gaps: beats at cycles 0,2,5, RLAST on 5 → rsp_valid asserted only those cycles, RDATA forwarded unchanged.
- RID=3 while ARID=2 → beat delivered to requester 2; id_err=1 and stays 1 after later good bursts.
- rst pulse during DATA after beat 2 of 4:
  - All outputs return to reset values immediately (async).
  - Stray RVALID beats after release produce no rsp_valid.
- Requester 0 re-requesting continuously, fixed priority → requester 2 never granted. RR mode → requester 2 granted within 3 bursts.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory read arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin arbitration when defined).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData
   } arb_state_e;

   // Requester slots; slot 0 wins ties under fixed priority.
   localparam int unsigned REQ_DCACHE = 0;
   localparam int unsigned REQ_ICACHE = 1;
   localparam int unsigned REQ_SBUF   = 2;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner select over the requester valids.
// MEM_ARB_RR_EN defined: round-robin search starting at rr_ptr_i.
// MEM_ARB_RR_EN undefined: fixed priority, lowest index wins.
module mem_arb_picker
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_valid_i,
`ifdef MEM_ARB_RR_EN
   input  logic [IDX_W-1:0]   rr_ptr_i,
`endif
   output logic               win_valid_o,
   output logic [IDX_W-1:0]   win_idx_o,
   output logic [NUM_REQ-1:0] win_oh_o
);

   // First valid requester found in search order wins.
   always_comb begin
      int unsigned cand;
      cand        = 0;
      win_valid_o = 1'b0;
      win_idx_o   = '0;
      win_oh_o    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef MEM_ARB_RR_EN
         cand = (32'(rr_ptr_i) + k) % NUM_REQ;
`else
         cand = k;
`endif
         if (!win_valid_o && req_valid_i[cand]) begin
            win_valid_o    = 1'b1;
            win_idx_o      = IDX_W'(cand);
            win_oh_o[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI read channel between the line-fill requesters, one burst at a time.
// Optional feature macro: MEM_ARB_RR_EN (round-robin instead of fixed priority).
module mem_read_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 3,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 4,
   parameter int unsigned ID_WIDTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
   output logic [NUM_REQ-1:0]            req_grant,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic                          rsp_last,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic [ADDR_WIDTH-1:0]         ARADDR,
   output logic [LEN_WIDTH-1:0]          ARLEN,
   output logic [ID_WIDTH-1:0]           ARID,
   output logic                          ARVALID,
   input  logic                          ARREADY,
   input  logic [DATA_WIDTH-1:0]         RDATA,
   input  logic [ID_WIDTH-1:0]           RID,
   input  logic                          RLAST,
   input  logic                          RVALID,
   output logic                          RREADY,
   output logic                          id_err
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [NUM_REQ-1:0]    owner_oh_q, owner_oh_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [LEN_WIDTH-1:0]  arlen_q, arlen_d;
   logic [ID_WIDTH-1:0]   arid_q, arid_d;
   logic                  id_err_q, id_err_d;

   logic                  win_valid;
   logic [IDX_W-1:0]      win_idx;
   logic [NUM_REQ-1:0]    win_oh;

`ifdef MEM_ARB_RR_EN
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

   mem_arb_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_valid_i (req_valid),
`ifdef MEM_ARB_RR_EN
      .rr_ptr_i    (rr_ptr_q),
`endif
      .win_valid_o (win_valid),
      .win_idx_o   (win_idx),
      .win_oh_o    (win_oh)
   );

   // Burst sequencing: arbitrate, hold the address phase, then pass beats through until RLAST.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      owner_oh_d = owner_oh_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arid_d     = arid_q;
      id_err_d   = id_err_q;
`ifdef MEM_ARB_RR_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      ARVALID    = 1'b0;
      RREADY     = 1'b0;
      req_grant  = '0;
      rsp_valid  = '0;
      rsp_last   = 1'b0;
      rsp_data   = '0;

      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               araddr_d   = req_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
               arlen_d    = req_len[32'(win_idx) * LEN_WIDTH +: LEN_WIDTH];
               arid_d     = ID_WIDTH'(win_idx);
               owner_d    = win_idx;
               owner_oh_d = win_oh;
               state_d    = StAddr;
            end
         end
         StAddr: begin
            ARVALID = 1'b1;
            if (ARREADY) begin
               req_grant = owner_oh_q;
               state_d   = StData;
`ifdef MEM_ARB_RR_EN
               rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
            end
         end
         StData: begin
            RREADY = 1'b1;
            if (RVALID) begin
               rsp_valid = owner_oh_q;
               rsp_data  = RDATA;
               rsp_last  = RLAST;
               // Mismatched IDs are still delivered; the flag only records the anomaly.
               if (RID != arid_q) begin
                  id_err_d = 1'b1;
               end
               if (RLAST) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and captured address-phase fields; reset abandons any burst in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         owner_oh_q <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arid_q     <= '0;
         id_err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         rr_ptr_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         owner_oh_q <= owner_oh_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arid_q     <= arid_d;
         id_err_q   <= id_err_d;
`ifdef MEM_ARB_RR_EN
         rr_ptr_q   <= rr_ptr_d;
`endif
      end
   end

   assign ARADDR = araddr_q;
   assign ARLEN  = arlen_q;
   assign ARID   = arid_q;
   assign id_err = id_err_q;

   // The owner must keep requesting until its address handshake completes.
   a_req_held: assert property (@(posedge clk) disable iff (rst)
                                (state_q == StAddr) |-> req_valid[owner_q]);

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter; follows MEM_ARB_RR_EN for expected orders.
module tb_mem_read_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [95:0] req_addr;
   logic [11:0] req_len;
   logic [2:0]  req_grant, rsp_valid;
   logic        rsp_last;
   logic [31:0] rsp_data, ARADDR, RDATA;
   logic [3:0]  ARLEN, ARID, RID;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, id_err;

   always #5 clk = ~clk;

   mem_read_arbiter dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
      .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_data(rsp_data),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARID(ARID), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RID(RID), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .id_err(id_err)
   );

   typedef struct {
      bit          is_grant;
      int          idx;
      logic [31:0] val;
      logic [3:0]  len;
      bit          last;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0, n_err = 0;
   int   beats_seen = 0, n_grant = 0;
   logic [2:0] last_grant = '0;
   logic [2:0] keep;
   int   ar_delay;
   int   gap[16];
   bit   rid_bad;
   bit   slave_busy = 1'b0;

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] beat_data(logic [31:0] a, int b);
      return a ^ (32'hCAFE_0000 + 32'(b));
   endfunction

   function automatic void push_burst(int idx, logic [31:0] addr, int len, int nbeats);
      exp_t e;
      e.is_grant = 1'b1; e.idx = idx; e.val = addr; e.len = 4'(len); e.last = 1'b0;
      exp_q.push_back(e);
      for (int b = 0; b < nbeats; b++) begin
         e.is_grant = 1'b0; e.val = beat_data(addr, b); e.last = (b == len - 1);
         exp_q.push_back(e);
      end
   endfunction

   function automatic void check_reset(string tag);
      check({tag, "_arvalid"}, 64'(ARVALID), 0);
      check({tag, "_rready"}, 64'(RREADY), 0);
      check({tag, "_araddr"}, 64'(ARADDR), 0);
      check({tag, "_arlen_arid"}, 64'({ARLEN, ARID}), 0);
      check({tag, "_grant_rspv"}, 64'({req_grant, rsp_valid}), 0);
      check({tag, "_rsp"}, 64'({rsp_last, rsp_data}), 0);
      check({tag, "_id_err"}, 64'(id_err), 0);
   endfunction

   // Memory slave: address handshake after ar_delay cycles, then beats with per-beat gaps.
   initial begin
      logic [31:0] a;
      logic [3:0]  l, id;
      ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RID = '0; RLAST = 1'b0;
      forever begin
         @(negedge clk);
         if (ARVALID && !rst) begin
            slave_busy = 1'b1;
            a = ARADDR; l = ARLEN; id = ARID;
            repeat (ar_delay) begin @(posedge clk); #1; end
            ARREADY = 1'b1;
            @(posedge clk); #1;
            ARREADY = 1'b0;
            for (int b = 0; b < int'(l); b++) begin
               repeat (gap[b]) begin @(posedge clk); #1; end
               RVALID = 1'b1;
               RDATA  = beat_data(a, b);
               RID    = rid_bad ? 4'd3 : id;
               RLAST  = (b == int'(l) - 1);
               @(posedge clk); #1;
               RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
            end
            slave_busy = 1'b0;
         end
      end
   end

   // Monitor: every grant or response beat pops the next expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         last_grant = req_grant;
         if (|req_grant || |rsp_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_output: grant=%b rsp_valid=%b required none",
                        req_grant, rsp_valid);
            end else begin
               e = exp_q.pop_front();
               if (e.is_grant) begin
                  check("req_grant", 64'(req_grant), 64'(1) << e.idx);
                  check("araddr", 64'(ARADDR), 64'(e.val));
                  check("arid", 64'(ARID), 64'(e.idx));
                  check("arlen", 64'(ARLEN), 64'(e.len));
               end else begin
                  check("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
                  check("rsp_data", 64'(rsp_data), 64'(e.val));
                  check("rsp_last", 64'(rsp_last), 64'(e.last));
                  beats_seen++;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         if (last_grant[i]) begin
            n_grant++;
            if (!keep[i]) req_valid[i] = 1'b0;
         end
      end
   endtask

   task automatic set_req(int i, logic [31:0] addr, int len);
      req_addr[i*32 +: 32] = addr;
      req_len[i*4 +: 4]    = 4'(len);
      req_valid[i]         = 1'b1;
   endtask

   task automatic wait_idle(string nm);
      int c = 0;
      while (!(exp_q.size() == 0 && !slave_busy && req_valid == 3'b000) && c < 400) begin
         step();
         c++;
      end
      if (c >= 400) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: pending=%0d required 0", nm, exp_q.size());
      end
      repeat (2) step();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      int c;
      rst = 1'b0; req_valid = '0; req_addr = '0; req_len = '0; keep = '0;
      ar_delay = 1; rid_bad = 1'b0;
      for (int i = 0; i < 16; i++) gap[i] = 0;
      #2 rst = 1'b1;
      #1 check_reset("por");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      step();

      // Single I-cache request, ARREADY two cycles into the address phase.
      ar_delay = 2;
      push_burst(REQ_ICACHE, 32'h0000_1040, 4, 4);
      set_req(REQ_ICACHE, 32'h0000_1040, 4);
      wait_idle("single");
      check("arid_held", 64'(ARID), 1);
      ar_delay = 1;

      // Simultaneous requests after one warm-up burst from requester 0.
      do_reset();
      push_burst(REQ_DCACHE, 32'h0000_2000, 2, 2);
      set_req(REQ_DCACHE, 32'h0000_2000, 2);
      wait_idle("warmup");
`ifdef MEM_ARB_RR_EN
      push_burst(1, 32'h0000_3040, 2, 2);
      push_burst(2, 32'h0000_4080, 1, 1);
      push_burst(0, 32'h0000_2000, 2, 2);
`else
      push_burst(0, 32'h0000_2000, 2, 2);
      push_burst(1, 32'h0000_3040, 2, 2);
      push_burst(2, 32'h0000_4080, 1, 1);
`endif
      set_req(0, 32'h0000_2000, 2);
      set_req(1, 32'h0000_3040, 2);
      set_req(2, 32'h0000_4080, 1);
      wait_idle("three_way");

      // Gapped beats at relative cycles 0, 2, 5.
      gap[0] = 0; gap[1] = 1; gap[2] = 2;
      push_burst(REQ_DCACHE, 32'h0000_6000, 3, 3);
      set_req(REQ_DCACHE, 32'h0000_6000, 3);
      wait_idle("gaps");
      for (int i = 0; i < 16; i++) gap[i] = 0;

      // Wrong RID: beats still delivered, sticky error.
      check("id_err_before", 64'(id_err), 0);
      rid_bad = 1'b1;
      push_burst(REQ_SBUF, 32'h0000_7080, 2, 2);
      set_req(REQ_SBUF, 32'h0000_7080, 2);
      wait_idle("bad_rid");
      rid_bad = 1'b0;
      check("id_err_set", 64'(id_err), 1);
      push_burst(REQ_ICACHE, 32'h0000_1100, 1, 1);
      set_req(REQ_ICACHE, 32'h0000_1100, 1);
      wait_idle("good_after_bad");
      check("id_err_sticky", 64'(id_err), 1);

      // Reset after beat 2 of 4; remaining beats become stray traffic.
      gap[3] = 2;
      push_burst(REQ_DCACHE, 32'h0000_5000, 4, 2);
      set_req(REQ_DCACHE, 32'h0000_5000, 4);
      c = 0;
      while (exp_q.size() != 0 && c < 100) begin step(); c++; end
      if (c >= 100) begin
         n_cmp++; n_err++;
         $display("FAIL rst_mid_wait: pending=%0d required 0", exp_q.size());
      end
      rst = 1'b1;
      #1 check_reset("rst_mid");
      @(posedge clk); #1;
      rst = 1'b0;
      check("rready_after_rst", 64'(RREADY), 0);
      c = 0;
      while (slave_busy && c < 50) begin step(); c++; end
      repeat (3) step();
      for (int i = 0; i < 16; i++) gap[i] = 0;

      // Requester 0 keeps re-requesting alongside requester 2.
      do_reset();
`ifdef MEM_ARB_RR_EN
      push_burst(0, 32'h0000_8000, 1, 1);
      push_burst(2, 32'h0000_9080, 1, 1);
      push_burst(0, 32'h0000_8000, 1, 1);
      push_burst(0, 32'h0000_8000, 1, 1);
`else
      for (int i = 0; i < 4; i++) push_burst(0, 32'h0000_8000, 1, 1);
      push_burst(2, 32'h0000_9080, 1, 1);
`endif
      n_grant = 0;
      keep[0] = 1'b1;
      set_req(0, 32'h0000_8000, 1);
      set_req(2, 32'h0000_9080, 1);
      c = 0;
      while (n_grant < 4 && c < 200) begin step(); c++; end
      if (c >= 200) begin
         n_cmp++; n_err++;
         $display("FAIL starve_wait: grants=%0d required 4", n_grant);
      end
      keep[0] = 1'b0;
      req_valid[0] = 1'b0;
      wait_idle("starve");

      check("leftover_expect", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
